// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - synchronous FIFO controller driving external storage
// Optional almost-full/almost-empty flags enabled by SYNC_FIFO_ALMOST_FLAG_EN.
module sync_fifo_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEPTH_LOG       = 8,
  parameter int ALMOST_FULL_TH  = 2**DEPTH_LOG-4,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_write_req,
  input  logic [WIDTH-1:0]     fifo_write_data,
  input  logic                 fifo_read_req,
  output logic [WIDTH-1:0]     fifo_read_data,
  output logic                 fifo_read_valid,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic [DEPTH_LOG:0]   fifo_count,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow,
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
  output logic                 fifo_almost_full,
  output logic                 fifo_almost_empty,
`endif
  output logic                 ram_write_req,
  output logic [DEPTH_LOG-1:0] ram_write_addr,
  output logic [DEPTH_LOG-1:0] ram_read_addr,
  output logic [WIDTH-1:0]     ram_write_data,
  input  logic [WIDTH-1:0]     ram_read_data
);

  localparam logic [DEPTH_LOG:0] PTR_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};

  logic [DEPTH_LOG:0] wptr_q, rptr_q;
  logic [DEPTH_LOG:0] wptr_n, rptr_n;
  logic               push, pop;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[DEPTH_LOG-1:0] == rptr_q[DEPTH_LOG-1:0]) &&
                      (wptr_q[DEPTH_LOG] != rptr_q[DEPTH_LOG]);

  // Acceptance is judged on pre-edge state, so an empty FIFO never falls through.
  assign push = fifo_write_req & ~fifo_full;
  assign pop  = fifo_read_req & ~fifo_empty;

  assign wptr_n = push ? wptr_q + PTR_ONE : wptr_q;
  assign rptr_n = pop  ? rptr_q + PTR_ONE : rptr_q;

  // Gate the write strobe so storage is never written while reset is held.
  assign ram_write_req  = push & rst_n;
  assign ram_write_addr = wptr_q[DEPTH_LOG-1:0];
  assign ram_write_data = fifo_write_data;
  assign ram_read_addr  = rptr_q[DEPTH_LOG-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      fifo_count      <= '0;
      fifo_read_data  <= '0;
      fifo_read_valid <= 1'b0;
      fifo_overflow   <= 1'b0;
      fifo_underflow  <= 1'b0;
    end else begin
      wptr_q          <= wptr_n;
      rptr_q          <= rptr_n;
      fifo_count      <= wptr_n - rptr_n;
      fifo_read_valid <= pop;
      fifo_overflow   <= fifo_write_req & fifo_full;
      fifo_underflow  <= fifo_read_req & fifo_empty;
      if (pop) begin
        fifo_read_data <= ram_read_data;
      end
    end
  end

`ifdef SYNC_FIFO_ALMOST_FLAG_EN
  localparam logic [DEPTH_LOG:0] AF_TH = (DEPTH_LOG+1)'(ALMOST_FULL_TH);
  localparam logic [DEPTH_LOG:0] AE_TH = (DEPTH_LOG+1)'(ALMOST_EMPTY_TH);

  logic [DEPTH_LOG:0] count_n;
  assign count_n = wptr_n - rptr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
    end else begin
      fifo_almost_full  <= (count_n >= AF_TH);
      fifo_almost_empty <= (count_n <= AE_TH);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_write_req;
  logic [7:0] fifo_write_data;
  logic       fifo_read_req;
  logic [7:0] fifo_read_data;
  logic       fifo_read_valid;
  logic       fifo_full, fifo_empty;
  logic [2:0] fifo_count;
  logic       fifo_overflow, fifo_underflow;
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
  logic       fifo_almost_full, fifo_almost_empty;
`endif
  logic       ram_write_req;
  logic [1:0] ram_write_addr, ram_read_addr;
  logic [7:0] ram_write_data, ram_read_data;

  logic [7:0] mem [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_req) mem[ram_write_addr] <= ram_write_data;
  end
  assign ram_read_data = mem[ram_read_addr];

  sync_fifo_ctrl #(
    .WIDTH(8), .DEPTH_LOG(2), .ALMOST_FULL_TH(3), .ALMOST_EMPTY_TH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_write_req(fifo_write_req), .fifo_write_data(fifo_write_data),
    .fifo_read_req(fifo_read_req), .fifo_read_data(fifo_read_data),
    .fifo_read_valid(fifo_read_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
    .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
`endif
    .ram_write_req(ram_write_req), .ram_write_addr(ram_write_addr),
    .ram_read_addr(ram_read_addr), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_write_req  = 1'b1;
    fifo_write_data = d;
    step();
    fifo_write_req  = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] d, input string name);
    fifo_read_req = 1'b1;
    step();
    fifo_read_req = 1'b0;
    checks++;
    if (fifo_read_valid !== 1'b1 || fifo_read_data !== d) begin
      errors++;
      $display("FAIL %s valid=%b data=%h expected valid=1 data=%h", name, fifo_read_valid, fifo_read_data, d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fifo_write_req = 1'b1;
    fifo_write_data = 8'h5A;
    fifo_read_req = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    #12;
    checks++;
    if (fifo_count !== 3'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
        fifo_read_data !== 8'h00 || fifo_read_valid !== 1'b0 || fifo_overflow !== 1'b0 ||
        fifo_underflow !== 1'b0 || ram_write_req !== 1'b0) begin
      errors++;
      $display("FAIL reset count=%0d empty=%b full=%b rd=%h rv=%b ov=%b un=%b wr=%b expected 0 1 0 00 0 0 0 0",
               fifo_count, fifo_empty, fifo_full, fifo_read_data, fifo_read_valid,
               fifo_overflow, fifo_underflow, ram_write_req);
    end
    fifo_write_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    push(8'h11); push(8'h22); push(8'h33);
    checks++;
    if (fifo_count !== 3'd3 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_count count=%0d empty=%b expected 3 0", fifo_count, fifo_empty);
    end
    pop_expect(8'h11, "basic_pop0");
    pop_expect(8'h22, "basic_pop1");
    pop_expect(8'h33, "basic_pop2");
    step();
    checks++;
    if (fifo_read_valid !== 1'b0 || fifo_empty !== 1'b1 || fifo_read_data !== 8'h33) begin
      errors++;
      $display("FAIL basic_drained valid=%b empty=%b data=%h expected 0 1 33", fifo_read_valid, fifo_empty, fifo_read_data);
    end
  endtask

  task automatic test_overflow();
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    checks++;
    if (fifo_full !== 1'b1 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_flag full=%b count=%0d expected 1 4", fifo_full, fifo_count);
    end
    push(8'hFF);
    checks++;
    if (fifo_overflow !== 1'b1 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL overflow_pulse ov=%b count=%0d expected 1 4", fifo_overflow, fifo_count);
    end
    step();
    checks++;
    if (fifo_overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear ov=%b expected 0", fifo_overflow);
    end
    pop_expect(8'hA0, "ovf_pop0");
    pop_expect(8'hA1, "ovf_pop1");
    pop_expect(8'hA2, "ovf_pop2");
    pop_expect(8'hA3, "ovf_pop3");
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_empty empty=%b expected 1", fifo_empty);
    end
  endtask

  task automatic test_underflow();
    fifo_read_req = 1'b1;
    step();
    fifo_read_req = 1'b0;
    checks++;
    if (fifo_underflow !== 1'b1 || fifo_read_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL underflow un=%b valid=%b count=%0d expected 1 0 0", fifo_underflow, fifo_read_valid, fifo_count);
    end
    fifo_write_req = 1'b1; fifo_write_data = 8'h5C; fifo_read_req = 1'b1;
    step();
    fifo_write_req = 1'b0; fifo_read_req = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || fifo_read_valid !== 1'b0 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_pushpop count=%0d valid=%b empty=%b expected 1 0 0", fifo_count, fifo_read_valid, fifo_empty);
    end
    pop_expect(8'h5C, "empty_pushpop_data");
  endtask

  task automatic test_full_pushpop();
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    fifo_write_req = 1'b1; fifo_write_data = 8'hAA; fifo_read_req = 1'b1;
    step();
    fifo_write_req = 1'b0; fifo_read_req = 1'b0;
    checks++;
    if (fifo_read_valid !== 1'b1 || fifo_read_data !== 8'hB0 || fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL full_pushpop valid=%b data=%h count=%0d expected 1 b0 3", fifo_read_valid, fifo_read_data, fifo_count);
    end
    pop_expect(8'hB1, "full_pp_pop1");
    pop_expect(8'hB2, "full_pp_pop2");
    pop_expect(8'hB3, "full_pp_pop3");
    checks++;
    if (fifo_empty !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL full_pp_aa_dropped empty=%b count=%0d expected 1 0", fifo_empty, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    push(8'hC0); push(8'hC1);
    for (int i = 0; i < 20; i++) begin
      fifo_write_req = 1'b1; fifo_write_data = 8'hC2 + 8'(i); fifo_read_req = 1'b1;
      step();
      checks++;
      if (fifo_read_valid !== 1'b1 || fifo_read_data !== 8'hC0 + 8'(i) || fifo_count !== 3'd2) begin
        errors++;
        $display("FAIL stream[%0d] valid=%b data=%h count=%0d expected 1 %h 2", i, fifo_read_valid, fifo_read_data, fifo_count, 8'hC0 + 8'(i));
      end
    end
    fifo_write_req = 1'b0; fifo_read_req = 1'b0;
    pop_expect(8'hD4, "stream_tail0");
    pop_expect(8'hD5, "stream_tail1");
  endtask

  task automatic test_async_reset();
    push(8'hE0); push(8'hE1); push(8'hE2);
    step();
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
    checks++;
    if (fifo_almost_full !== 1'b1 || fifo_almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL almost_at3 af=%b ae=%b expected 1 0", fifo_almost_full, fifo_almost_empty);
    end
`endif
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 3'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset count=%0d empty=%b full=%b expected 0 1 0", fifo_count, fifo_empty, fifo_full);
    end
`ifdef SYNC_FIFO_ALMOST_FLAG_EN
    checks++;
    if (fifo_almost_full !== 1'b0 || fifo_almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL almost_reset af=%b ae=%b expected 0 1", fifo_almost_full, fifo_almost_empty);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (fifo_empty !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL post_reset empty=%b count=%0d expected 1 0", fifo_empty, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_full_pushpop();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
